// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter sharing the data memory's load and store channels.
// Each channel: round-robin with grant hold, and an owner FIFO that steers in-order responses.

module dmem_arb_chan #(
    parameter int PW        = 36,
    parameter int MAX_OUTST = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid_i,
    input  logic [1:0][PW-1:0]   req_payload_i,
    output logic [1:0]           req_ready_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [PW-1:0]        m_payload_o,
    input  logic                 m_resp_valid_i,
    output logic                 m_resp_ready_o,
    output logic [1:0]           resp_valid_o,
    input  logic [1:0]           resp_ready_i
);
    localparam int AW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW = $clog2(MAX_OUTST + 1);

    logic          last_q, last_d;
    logic          hold_q, hold_d;
    logic          hold_id_q, hold_id_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          owner_q [MAX_OUTST];

    logic win, full, empty, head, push, pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(MAX_OUTST - 1)) ? '0 : p + AW'(1);
    endfunction

    // With no hold, contention goes to the requester after the last winner;
    // otherwise the sole valid requester (index 0 when idle).
    always_comb begin
        win = 1'b0;
        if (hold_q)
            win = hold_id_q;
        else if (&req_valid_i)
            win = ~last_q;
        else
            win = req_valid_i[1];
    end

    assign full  = (count_q == CW'(MAX_OUTST));
    assign empty = (count_q == '0);
    assign head  = owner_q[rd_ptr_q];

    assign m_valid_o      = !rst && (|req_valid_i) && !full;
    assign m_payload_o    = m_valid_o ? req_payload_i[win] : '0;
    assign push           = m_valid_o && m_ready_i;
    assign pop            = !rst && m_resp_valid_i && !empty && resp_ready_i[head];
    // Responses with no recorded owner are drained and dropped.
    assign m_resp_ready_o = rst || empty || resp_ready_i[head];

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign req_ready_o[gi]  = !rst && !full && m_ready_i && (win == 1'(gi));
        assign resp_valid_o[gi] = !rst && m_resp_valid_i && !empty && (head == 1'(gi));
    end

    always_comb begin
        last_d    = last_q;
        hold_d    = hold_q;
        hold_id_d = hold_id_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q + CW'(push) - CW'(pop);
        if (push) begin
            last_d   = win;
            hold_d   = 1'b0;
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else if (m_valid_o && !m_ready_i) begin
            hold_d    = 1'b1;
            hold_id_d = win;
        end
        if (pop)
            rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q    <= 1'b1;
            hold_q    <= 1'b0;
            hold_id_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            last_q    <= last_d;
            hold_q    <= hold_d;
            hold_id_q <= hold_id_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            owner_q[wr_ptr_q] <= win;
    end
endmodule

module dmem_port_arbiter #(
    parameter int LDTAG_W   = 4,
    parameter int MAX_OUTST = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              r_ld_valid,
    output logic [1:0]              r_ld_ready,
    input  logic [1:0][31:0]        r_ld_addr,
    input  logic [1:0][LDTAG_W-1:0] r_ld_tag,
    output logic [1:0]              r_ld_resp_valid,
    input  logic [1:0]              r_ld_resp_ready,
    input  logic [1:0]              r_st_valid,
    output logic [1:0]              r_st_ready,
    input  logic [1:0][31:0]        r_st_addr,
    input  logic [1:0][63:0]        r_st_wdata,
    input  logic [1:0][7:0]         r_st_wstrb,
    output logic [1:0]              r_st_resp_valid,
    input  logic [1:0]              r_st_resp_ready,
    output logic                    m_ld_valid,
    input  logic                    m_ld_ready,
    output logic [31:0]             m_ld_addr,
    output logic [LDTAG_W-1:0]      m_ld_tag,
    input  logic                    m_ld_resp_valid,
    output logic                    m_ld_resp_ready,
    output logic                    m_st_valid,
    input  logic                    m_st_ready,
    output logic [31:0]             m_st_addr,
    output logic [63:0]             m_st_wdata,
    output logic [7:0]              m_st_wstrb,
    input  logic                    m_st_resp_valid,
    output logic                    m_st_resp_ready
);
    localparam int LD_PW = 32 + LDTAG_W;
    localparam int ST_PW = 32 + 64 + 8;

    logic [1:0][LD_PW-1:0] ld_payload;
    logic [1:0][ST_PW-1:0] st_payload;

    for (genvar gi = 0; gi < 2; gi++) begin : g_pack
        assign ld_payload[gi] = {r_ld_addr[gi], r_ld_tag[gi]};
        assign st_payload[gi] = {r_st_addr[gi], r_st_wdata[gi], r_st_wstrb[gi]};
    end

    dmem_arb_chan #(.PW(LD_PW), .MAX_OUTST(MAX_OUTST)) u_ld (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (r_ld_valid),
        .req_payload_i  (ld_payload),
        .req_ready_o    (r_ld_ready),
        .m_valid_o      (m_ld_valid),
        .m_ready_i      (m_ld_ready),
        .m_payload_o    ({m_ld_addr, m_ld_tag}),
        .m_resp_valid_i (m_ld_resp_valid),
        .m_resp_ready_o (m_ld_resp_ready),
        .resp_valid_o   (r_ld_resp_valid),
        .resp_ready_i   (r_ld_resp_ready)
    );

    dmem_arb_chan #(.PW(ST_PW), .MAX_OUTST(MAX_OUTST)) u_st (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (r_st_valid),
        .req_payload_i  (st_payload),
        .req_ready_o    (r_st_ready),
        .m_valid_o      (m_st_valid),
        .m_ready_i      (m_st_ready),
        .m_payload_o    ({m_st_addr, m_st_wdata, m_st_wstrb}),
        .m_resp_valid_i (m_st_resp_valid),
        .m_resp_ready_o (m_st_resp_ready),
        .resp_valid_o   (r_st_resp_valid),
        .resp_ready_i   (r_st_resp_ready)
    );
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-requester arbiter in front of the single-port data memory model. Requester 0 is the LSU; requester 1 is the secondary master (debug loader / DMA). The block shares the memory's load and store channels between the two using round-robin with grant hold. It tracks up to MAX_OUTST in-flight requests per channel in owner FIFOs, so each in-order memory response is steered back to the requester that issued it. Response payloads (`ld_resp_data`/`ld_resp_tag`/`ld_resp_err`) fan out from memory to both requesters directly; this block steers only response valid/ready.

## Interface
- LDTAG_W, 4, load tag width, passed through unchanged
- MAX_OUTST, 2, owner-FIFO depth per channel (power of two, ≥1)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- r_ld_valid  in  [1:0]  per-requester load request valid
- r_ld_ready  out  [1:0]  per-requester load accept
- r_ld_addr  in  [1:0][31:0]  load byte address
- r_ld_tag  in  [1:0][LDTAG_W-1:0]  load tag
- r_ld_resp_valid  out  [1:0]  load response valid, steered to owner
- r_ld_resp_ready  in  [1:0]  load response accept
- r_st_valid  in  [1:0]  store request valid
- r_st_ready  out  [1:0]  store accept
- r_st_addr  in  [1:0][31:0]  store byte address
- r_st_wdata  in  [1:0][63:0]  store data
- r_st_wstrb  in  [1:0][7:0]  store byte strobes
- r_st_resp_valid  out  [1:0]  store completion, steered to owner
- r_st_resp_ready  in  [1:0]  store completion accept
- m_ld_valid / m_ld_ready  out / in  1  memory load request handshake
- m_ld_addr  out  32  muxed load address
- m_ld_tag  out  LDTAG_W  muxed load tag
- m_ld_resp_valid / m_ld_resp_ready  in / out  1  memory load response handshake
- m_st_valid / m_st_ready  out / in  1  memory store request handshake
- m_st_addr  out  32  muxed store address
- m_st_wdata  out  64  muxed store data
- m_st_wstrb  out  8  muxed store strobes
- m_st_resp_valid / m_st_resp_ready  in / out  1  memory store completion handshake

## Operation
- The load and store channels are identical and fully independent. Each has its own RR pointer, hold register and owner FIFO. Load is described here.
- **Winner selection:** if `hold` is set, the winner is `hold_id`. Otherwise the winner is the valid requester after `last` in RR order. A sole valid requester always wins.
- `m_ld_valid` = (any `r_ld_valid`) & !fifo_full.
- `m_ld_addr`/`m_ld_tag` come from the winner. They are 0 when `m_ld_valid` = 0.
- `r_ld_ready[w]` = `m_ld_ready` & !fifo_full for winner w. The loser's ready is 0.
- **On handshake:** push w into the owner FIFO, set `last` ← w, clear `hold`.
- **Hold:** if `m_ld_valid` & !`m_ld_ready`, set `hold` and `hold_id` ← w. This keeps the presented request stable until accepted. A requester must not drop valid before it is accepted.
- **Response steer:** h = FIFO head.
  - `r_ld_resp_valid[h]` = `m_ld_resp_valid` & !empty.
  - `m_ld_resp_ready` = `r_ld_resp_ready[h]` when !empty.
  - Pop on the `m_ld_resp` handshake.
- **Response with empty FIFO** (stray or post-reset): `m_ld_resp_ready` = 1, the beat is discarded, and no `r_ld_resp_valid` is raised.
- **Full FIFO:** full blocks new grants even if a pop occurs in the same cycle. Push and pop in the same cycle are allowed when not full.
- Stores use the same rules with `wdata`/`wstrb` muxed from the winner and `m_st_resp` popping the store FIFO.

## Timing
- Request path and response steering are combinational (0-cycle). Pointer, hold and FIFO update on the clk edge.
- **Reset (rst = 1 at an edge):**
  - `last` ← 1, so requester 0 wins the first contention.
  - `hold` ← 0.
  - Both FIFOs are emptied.
- **Outputs while rst = 1:** all `r_*_ready`, `r_*_resp_valid` and `m_*_valid` are forced to 0. `m_*_resp_ready` is forced to 1 (drain).
- **Reset mid-operation:** in-flight ownership is lost. Memory responses arriving later are discarded per the empty-FIFO rule.
- **Ordering:** responses are delivered strictly in grant order. A stalled head owner blocks the other requester's later response. No reordering.
- **Throughput:** one grant per channel per cycle when `m_*_ready` = 1 and the FIFO is not full.

## Test plan
- **Both load valid, cycle 0 after reset, `m_ld_ready` = 1, 2-cycle memory, tags 3/7:**
  - Cycle 0 grants r0, cycle 1 grants r1.
  - `r_ld_resp_valid` = 01 with tag 3, then 10 with tag 7.
- **Grant hold:** r1 load valid at addr 0x40, `m_ld_ready` = 0 for 3 cycles, r0 valid from cycle 1.
  - `m_ld_addr` stays 0x40 until the cycle-3 handshake.
  - r0 is granted in cycle 4.
- **Full FIFO:** MAX_OUTST = 2, no responses, three r0 loads.
  - Third `r_ld_ready` = 0 until the first response handshake.
  - Third load is granted in the cycle after that pop.
- **Head-of-line:** r0 owns the head with `r_ld_resp_ready[0]` = 0 for 4 cycles, while r1's response is queued behind it.
  - `m_ld_resp_ready` = 0, and r1 sees no valid until r0 accepts.
- **Concurrent channels:** r0 store (wstrb 0x0F, data 0xDEADBEEF) and r1 load in the same cycle.
  - Both are granted that cycle.
  - `r_st_resp_valid` = 01 and `r_ld_resp_valid` = 10 on their respective completions.
- **Reset with 2 loads outstanding:** after rst, memory returns 2 responses.
  - Both are discarded (`m_ld_resp_ready` = 1, `r_ld_resp_valid` = 00).
  - The next contention grants r0 first.
